// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, RV32 width codes and access lengths for the LSU
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] LEN_B = 32'd1;
  localparam logic [31:0] LEN_H = 32'd2;
  localparam logic [31:0] LEN_W = 32'd4;

  // The reserved size code 11 maps to a word; such requests are always rejected anyway.
  function automatic logic [31:0] len_of(input logic [1:0] size);
    case (size)
      2'b00:   len_of = LEN_B;
      2'b01:   len_of = LEN_H;
      default: len_of = LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - length decode, request legality check, store byte mask and load extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  chk_funct3_i,
  input  logic        chk_we_i,
  input  logic [1:0]  chk_addr_lo_i,
  output logic        err_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] len_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] chk_len;
  logic        illegal;
  logic        misaligned;

  // The legality check looks at the incoming request; the datapath uses the latched one.
  always_comb begin
    chk_len    = len_of(chk_funct3_i[1:0]);
    illegal    = (chk_funct3_i == 3'b011) || (chk_funct3_i == 3'b110) ||
                 (chk_funct3_i == 3'b111) || (chk_we_i && chk_funct3_i[2]);
    misaligned = ((chk_len == LEN_H) && chk_addr_lo_i[0]) ||
                 ((chk_len == LEN_W) && (chk_addr_lo_i != 2'b00));
    err_o      = illegal || misaligned;
  end

  always_comb begin
    len_o = len_of(funct3_i[1:0]);
    case (funct3_i[1:0])
      2'b00:   wdata_o = {24'h0, wdata_i[7:0]};
      2'b01:   wdata_o = {16'h0, wdata_i[15:0]};
      default: wdata_o = wdata_i;
    endcase
    case (funct3_i)
      F3_B:    rdata_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
      F3_H:    rdata_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      F3_BU:   rdata_o = {24'h0, rdata_i[7:0]};
      F3_HU:   rdata_o = {16'h0, rdata_i[15:0]};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding RV32 load/store unit with one-cycle memory strobe
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_len,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt
);

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] ld_cnt_q;
  logic [31:0] st_cnt_q;

  logic        req_err;
  logic        accept;
  logic [31:0] rdata_ext;

  lsu_align u_align (
    .chk_funct3_i  (req_funct3),
    .chk_we_i      (req_we),
    .chk_addr_lo_i (req_addr[1:0]),
    .err_o         (req_err),
    .funct3_i      (funct3_q),
    .wdata_i       (wdata_q),
    .rdata_i       (mem_rdata),
    .len_o         (mem_len),
    .wdata_o       (mem_wdata),
    .rdata_o       (rdata_ext)
  );

  assign accept     = req_valid && req_ready;
  assign mem_addr   = addr_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign ld_cnt     = ld_cnt_q;
  assign st_cnt     = st_cnt_q;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_valid = !we_q;
        mem_we    = we_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      ld_cnt_q     <= 32'h0;
      st_cnt_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q         <= req_we;
        funct3_q     <= req_funct3;
        addr_q       <= req_addr;
        wdata_q      <= req_wdata;
        resp_err_q   <= req_err;
        resp_rdata_q <= 32'h0;
      end
      // Load data is captured on the same edge that retires the access.
      if (state_q == ST_ACCESS) begin
        if (we_q) begin
          st_cnt_q <= st_cnt_q + 32'd1;
        end else begin
          ld_cnt_q     <= ld_cnt_q + 32'd1;
          resp_rdata_q <= rdata_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu against a behavioural model
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_len;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_ld = 32'h0;
  logic [31:0] exp_st = 32'h0;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata),
    .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_len(input logic [2:0] f3);
    int sz = int'(f3) % 4;
    if (sz == 0) return 32'd1;
    if (sz == 1) return 32'd2;
    return 32'd4;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    return (addr % model_len(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_mask(input logic [2:0] f3, input logic [31:0] d);
    longint unsigned lim = 64'd1 << (8 * model_len(f3));
    return 32'(longint'(d) % lim);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] d);
    int unsigned v;
    case (f3)
      3'd0: begin v = d % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = d % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = d % 256;
      3'd5: v = d % 65536;
      default: v = d;
    endcase
    return v;
  endfunction

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int hold);
    logic        err;
    logic [31:0] exp_rd;
    err    = model_err(we, f3, addr);
    exp_rd = (we || err) ? 32'h0 : model_load(f3, rdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_rdata = rdata; resp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL req_ready_busy: got %b want 0", req_ready); end
    total++;
    if (mem_valid !== (!err && !we) || mem_we !== (!err && we)) begin
      bad++; $display("FAIL strobes_n1: got v=%b w=%b want v=%b w=%b", mem_valid, mem_we, !err && !we, !err && we);
    end
    total++;
    if (mem_addr !== addr) begin bad++; $display("FAIL mem_addr: got %h want %h", mem_addr, addr); end
    if (!err) begin
      total++;
      if (mem_len !== model_len(f3)) begin bad++; $display("FAIL mem_len: got %0d want %0d", mem_len, model_len(f3)); end
      if (we) begin
        total++;
        if (mem_wdata !== model_mask(f3, wdata)) begin
          bad++; $display("FAIL mem_wdata: got %h want %h", mem_wdata, model_mask(f3, wdata));
        end
      end
      total++;
      if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_early: got %b want 0", resp_valid); end
      @(posedge clk); #1;
      mem_rdata = $urandom;
      if (we) exp_st = exp_st + 32'd1; else exp_ld = exp_ld + 32'd1;
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL strobes_n2: got v=%b w=%b want 0 0", mem_valid, mem_we);
      end
    end
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_err !== err || resp_rdata !== exp_rd) begin
        bad++; $display("FAIL resp[%0d]: got v=%b e=%b d=%h want v=1 e=%b d=%h", i, resp_valid, resp_err, resp_rdata, err, exp_rd);
      end
      total++;
      if (req_ready !== 1'b0 || mem_valid !== 1'b0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL resp_idle_sig[%0d]: got rdy=%b v=%b w=%b want 0 0 0", i, req_ready, mem_valid, mem_we);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL back_idle: got v=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    total++;
    if (ld_cnt !== exp_ld || st_cnt !== exp_st) begin
      bad++; $display("FAIL counters: got ld=%h st=%h want ld=%h st=%h", ld_cnt, st_cnt, exp_ld, exp_st);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_valid !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: got rdy=%b rv=%b mv=%b mw=%b want 1 0 0 0", req_ready, resp_valid, mem_valid, mem_we);
    end
    total++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_data: got rd=%h e=%b a=%h wd=%h want 0", resp_rdata, resp_err, mem_addr, mem_wdata);
    end
    total++;
    if (ld_cnt !== 32'h0 || st_cnt !== 32'h0) begin
      bad++; $display("FAIL reset_cnt: got ld=%h st=%h want 0 0", ld_cnt, st_cnt);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h0000_0080, 0);
    txn(1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678, 32'hDEAD_BEEF, 0);
    txn(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h5555_AAAA, 0);
    txn(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 3);
    txn(1'b0, 3'b101, 32'h0000_0006, 32'h0, 32'h0001_8001, 1);
    txn(1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      txn(1'($urandom), 3'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010; mem_rdata = 32'h1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_access: got %b want 1", mem_valid); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_valid !== 1'b0 || mem_we !== 1'b0 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_access_strobes: got v=%b w=%b rv=%b want 0 0 0", mem_valid, mem_we, resp_valid);
    end
    total++;
    if (ld_cnt !== 32'h0 || st_cnt !== 32'h0) begin
      bad++; $display("FAIL rst_access_cnt: got ld=%h st=%h want 0 0", ld_cnt, st_cnt);
    end
    exp_ld = 32'h0; exp_st = 32'h0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || ld_cnt !== 32'h0) begin
      bad++; $display("FAIL rst_access_after: got rv=%b ld=%h want 0 0", resp_valid, ld_cnt);
    end
    txn(1'b1, 3'b010, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0000_0101;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    total++;
    if (resp_valid !== 1'b0 || st_cnt !== 32'h0 || resp_rdata !== 32'h0) begin
      bad++; $display("FAIL rst_resp: got rv=%b st=%h rd=%h want 0 0 0", resp_valid, st_cnt, resp_rdata);
    end
    exp_ld = 32'h0; exp_st = 32'h0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.st_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.st_cnt_q;
    exp_st = 32'hFFFF_FFFF;
    total++;
    if (st_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL st_preload: got %h want ffffffff", st_cnt); end
    txn(1'b1, 3'b010, 32'h8000_0000, 32'h0BAD_CAFE, 32'h0, 0);
    total++;
    if (st_cnt !== 32'h0) begin bad++; $display("FAIL st_wrap: got %h want 0", st_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
